beep_arbiter: RTL
=================

BEEP_ARBITER -- requirements
Module: beep_arbiter

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, clock frequency in Hz (informational; used for derived defaults).
REQ-002 Parameter ACCENT_CYC, default 500000, accent pulse length in clk cycles (10 ms).
REQ-003 Parameter BEAT_CYC, default 250000, normal beat pulse length in cycles (5 ms).
REQ-004 Parameter CLICK_CYC, default 50000, key-click pulse length in cycles (1 ms).
REQ-005 Parameter GAP_CYC, default 5000, enforced silence after a completed pulse in cycles (0.1 ms).
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 reset  input  1  reset; one clock, synchronous, active-high.
REQ-008 enable  input  1  buzzer enable; low = mute.
REQ-009 req_accent  input  1  single-cycle request for an accent beep.
REQ-010 req_beat  input  1  single-cycle request for a normal beat beep.
REQ-011 req_click  input  1  single-cycle request for a key-click beep.
REQ-012 beep_n  output  1  buzzer drive, active low, registered.
REQ-013 busy  output  1  high in PULSE or GAP state.
REQ-014 grant  output  3  one-cycle one-hot pulse, bit0 accent / bit1 beat / bit2 click, asserted in the first low cycle of the granted pulse.
REQ-015 drop  output  3  one-cycle one-hot-per-bit pulse marking a discarded request, same bit order.

Function
REQ-016 Requests SHALL latch into a 3-bit pending register; arbitration SHALL use (pending OR req) so an idle arbiter responds with no extra cycle.
REQ-017 Priority SHALL be fixed: accent > beat > click.
REQ-018 FSM states SHALL be IDLE, PULSE, GAP.
REQ-019 IDLE: if any candidate, grant the highest, clear its pending bit, load the counter with its length, enter PULSE; beep_n and grant go active in the cycle after the request is sampled (latency 1).
REQ-020 PULSE: beep_n low for exactly the granted length in cycles, then GAP.
REQ-021 GAP: beep_n high for exactly GAP_CYC cycles, then IDLE; pending requests wait.
REQ-022 A request of strictly higher priority than the active pulse SHALL preempt it in PULSE or GAP: new pulse starts next cycle, counter reloaded, no gap, new grant pulse; the preempted pulse is not resumed and not reported as drop.
REQ-023 A request whose pending bit is already set, or equal to the class currently in PULSE, SHALL be discarded with a drop pulse on its bit the next cycle.
REQ-024 Simultaneous requests SHALL all latch; they are served in priority order, each followed by its gap.
REQ-025 enable low SHALL force beep_n high next cycle, return to IDLE, clear pending, and drop every arriving request (drop pulse, no grant).
REQ-026 Counter SHALL be 20 bits unsigned; any length parameter of 0 or above 2^20-1 is illegal (elaboration error).

Reset
REQ-027 On reset: beep_n=1, busy=0, grant=0, drop=0, pending=0, counter=0, state IDLE; requests in the reset cycle are ignored.
REQ-028 Reset mid-pulse SHALL end the pulse at the next edge with no drop or grant reported.

Structure
REQ-029 Package metronome_pkg SHALL hold the state enum, requester index constants (ACC=0, BEAT=1, CLICK=2) and default pulse/gap lengths.
REQ-030 One sub-module, pulse_timer (loadable 20-bit down-counter with done flag), SHALL time both PULSE and GAP.

Verification (ACCENT_CYC=8, BEAT_CYC=4, CLICK_CYC=2, GAP_CYC=3)
REQ-031 req_beat at cycle 10, idle -> grant=010 at 11, beep_n low 11-14, high 15-17, busy low from 18.
REQ-032 req_accent, req_beat, req_click same cycle 5 -> accent low 6-13, gap 14-16, beat low 17-20, gap 21-23, click low 24-25; no drop.
REQ-033 req_click at 0, req_accent at 1 -> click low cycle 1 only, accent grant at 2, low 2-9; no drop.
REQ-034 req_beat at 0, req_beat at 2 -> drop=010 at 3, single beat pulse 1-4.
REQ-035 enable low during accent pulse at cycle 4 -> beep_n high at 5, busy 0 at 5, req_click at 6 -> drop=100 at 7.
REQ-036 reset asserted at cycle 3 of a beat pulse -> beep_n=1, pending=0, all outputs at reset values from the next edge.

Source files
------------

// File: rtl/metronome_pkg.sv
// Shared types and constants for the beep arbiter and its pulse timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, requester indices (ACC/BEAT/CLICK),
// default pulse/gap lengths, counter width and a priority picker.
package metronome_pkg;

    localparam int CNT_W   = 20;
    localparam int MAX_LEN = (1 << CNT_W) - 1;
    localparam int NUM_REQ = 3;

    // Requester indices; lower index means higher priority.
    localparam int ACC   = 0;
    localparam int BEAT  = 1;
    localparam int CLICK = 2;

    localparam int DEF_CLK_FREQ   = 50_000_000;
    localparam int DEF_ACCENT_CYC = 500_000;
    localparam int DEF_BEAT_CYC   = 250_000;
    localparam int DEF_CLICK_CYC  = 50_000;
    localparam int DEF_GAP_CYC    = 5_000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_e;

    typedef logic [1:0] req_idx_t;

    // Index of the highest-priority set bit; caller checks for any bit set.
    function automatic req_idx_t prio_idx(input logic [NUM_REQ-1:0] v);
        if (v[ACC]) begin
            return req_idx_t'(ACC);
        end else if (v[BEAT]) begin
            return req_idx_t'(BEAT);
        end else begin
            return req_idx_t'(CLICK);
        end
    endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable 20-bit down-counter timing both the beep pulse and the gap.
// Latency: done_o is high during the last cycle of a loaded interval.
// Backpressure: none; load and clear take effect at the next edge.
//
// Ports: clk_i, reset_i (sync, active-high), clear_i (force to 0),
//        load_i/load_val_i (start an interval of load_val_i cycles),
//        done_o (interval finishes this cycle).
module pulse_timer
    import metronome_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // The counter holds the cycles remaining including the current one,
    // so a load of N yields N cycles with done_o in the N-th.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/beep_arbiter.sv
// Arbitrates accent/beat/click beep requests onto one active-low buzzer.
// Latency: 1 cycle from request sample to beep_n low and grant pulse.
// Backpressure: none; requests that cannot be queued pulse their drop bit.
//
// Ports: clk, reset (sync, active-high), enable (low = mute),
//        req_accent/req_beat/req_click (single-cycle requests),
//        beep_n (registered buzzer drive), busy (PULSE or GAP),
//        grant[2:0] / drop[2:0] one-cycle pulses, bit0 accent, bit1 beat,
//        bit2 click.
module beep_arbiter
    import metronome_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int ACCENT_CYC = DEF_ACCENT_CYC,
    parameter int BEAT_CYC   = DEF_BEAT_CYC,
    parameter int CLICK_CYC  = DEF_CLICK_CYC,
    parameter int GAP_CYC    = DEF_GAP_CYC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       req_accent,
    input  logic       req_beat,
    input  logic       req_click,
    output logic       beep_n,
    output logic       busy,
    output logic [2:0] grant,
    output logic [2:0] drop
);

    // ------------------------------------------------------------------
    // Parameter legality: every length must fit the 20-bit counter and be
    // non-zero.
    // ------------------------------------------------------------------
    if (CLK_FREQ <= 0) begin : g_bad_clk
        $error("beep_arbiter: CLK_FREQ must be positive");
    end
    if (ACCENT_CYC < 1 || ACCENT_CYC > MAX_LEN) begin : g_bad_acc
        $error("beep_arbiter: ACCENT_CYC out of range 1..2^20-1");
    end
    if (BEAT_CYC < 1 || BEAT_CYC > MAX_LEN) begin : g_bad_beat
        $error("beep_arbiter: BEAT_CYC out of range 1..2^20-1");
    end
    if (CLICK_CYC < 1 || CLICK_CYC > MAX_LEN) begin : g_bad_click
        $error("beep_arbiter: CLICK_CYC out of range 1..2^20-1");
    end
    if (GAP_CYC < 1 || GAP_CYC > MAX_LEN) begin : g_bad_gap
        $error("beep_arbiter: GAP_CYC out of range 1..2^20-1");
    end

    localparam logic [CNT_W-1:0] LEN_ACC   = CNT_W'(ACCENT_CYC);
    localparam logic [CNT_W-1:0] LEN_BEAT  = CNT_W'(BEAT_CYC);
    localparam logic [CNT_W-1:0] LEN_CLICK = CNT_W'(CLICK_CYC);
    localparam logic [CNT_W-1:0] LEN_GAP   = CNT_W'(GAP_CYC);

    function automatic logic [CNT_W-1:0] len_of(input req_idx_t idx);
        case (idx)
            req_idx_t'(ACC):  return LEN_ACC;
            req_idx_t'(BEAT): return LEN_BEAT;
            default:          return LEN_CLICK;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e               state_q, state_d;
    req_idx_t             active_q, active_d;
    logic [NUM_REQ-1:0]   pending_q, pending_d;
    logic                 beep_n_q, beep_n_d;
    logic                 busy_q, busy_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   drop_q, drop_d;

    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   active_mask;
    logic [NUM_REQ-1:0]   req_ok;
    logic [NUM_REQ-1:0]   cand;
    logic                 cand_vld;
    req_idx_t             cand_idx;
    logic                 start;

    logic                 tmr_clear;
    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_val;
    logic                 tmr_done;

    assign req = {req_click, req_beat, req_accent};

    // ------------------------------------------------------------------
    // Request filtering and candidate selection
    // ------------------------------------------------------------------
    always_comb begin
        active_mask = '0;
        drop_d      = '0;
        if (state_q == PULSE) begin
            active_mask = NUM_REQ'(1) << active_q;
        end
        // A request is lost if muted, if its class already waits, or if it
        // repeats the class currently sounding.
        if (!enable) begin
            drop_d = req;
        end else begin
            drop_d = req & (pending_q | active_mask);
        end
        req_ok   = req & ~drop_d;
        // Live requests join the candidates directly so an idle arbiter
        // answers in the very next cycle.
        cand     = pending_q | req_ok;
        cand_vld = |cand;
        cand_idx = prio_idx(cand);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        grant_d   = '0;
        start     = 1'b0;
        tmr_clear = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;

        if (!enable) begin
            state_d   = IDLE;
            tmr_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    start = cand_vld;
                end
                PULSE: begin
                    // Strictly higher priority cuts the pulse short.
                    if (cand_vld && (cand_idx < active_q)) begin
                        start = 1'b1;
                    end else if (tmr_done) begin
                        state_d  = GAP;
                        tmr_load = 1'b1;
                        tmr_val  = LEN_GAP;
                    end
                end
                GAP: begin
                    // Higher priority skips the gap; otherwise the next
                    // waiter starts right after the last gap cycle.
                    if (cand_vld && ((cand_idx < active_q) || tmr_done)) begin
                        start = 1'b1;
                    end else if (tmr_done) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (start) begin
            state_d  = PULSE;
            active_d = cand_idx;
            grant_d  = NUM_REQ'(1) << cand_idx;
            tmr_load = 1'b1;
            tmr_val  = len_of(cand_idx);
        end

        pending_d = enable ? (cand & ~grant_d) : '0;
        beep_n_d  = (state_d != PULSE);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            active_q  <= '0;
            pending_q <= '0;
            beep_n_q  <= 1'b1;
            busy_q    <= 1'b0;
            grant_q   <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            beep_n_q  <= beep_n_d;
            busy_q    <= busy_d;
            grant_q   <= grant_d;
            drop_q    <= drop_d;
        end
    end

    pulse_timer u_timer (
        .clk_i      (clk),
        .reset_i    (reset),
        .clear_i    (tmr_clear),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    assign beep_n = beep_n_q;
    assign busy   = busy_q;
    assign grant  = grant_q;
    assign drop   = drop_q;

endmodule
